// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with write FIFO, build-time framing, run-time parity
// Ports: clk; rst (synchronous, active-low); valid/din/rdy write side of the FIFO;
//        parity_mode (00/11 none, 01 even, 10 odd); clr_overflow; tx serial line;
//        busy (frame in progress); count (FIFO occupancy); overflow (sticky write-while-full).
// Optional feature: define UART_TX_PARITY_EN to compile in the parity bit and PARITY state.
module uart_tx_cfg #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [DATA_BITS-1:0]          din,
  output logic                          rdy,
  input  logic [1:0]                    parity_mode,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [AW:0]    FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  RELOAD    = CW'(DIV - 1);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_HZ / BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr;
  logic [2:0]           state;
  logic [CW-1:0]        baud;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shifter, head;
  logic                 tick, push, pop, last_stop;
  assign head      = mem[rptr[AW-1:0]];
  assign count     = wptr - rptr;
  assign rdy       = count != FULL;
  assign busy      = state != IDLE;
  assign tick      = busy && baud == '0;
  assign last_stop = state == STOP && tick && stop_idx == LAST_STOP;
  // the next frame starts straight out of the final stop tick, so there is no idle gap
  assign pop       = count != '0 && (state == IDLE || last_stop);
  assign push      = valid && rdy;
`ifdef UART_TX_PARITY_EN
  logic par_en, par_bit;
  // mode is latched at pop so mid-frame changes only reach the next frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else if (pop) begin
      par_en  <= ^parity_mode;
      par_bit <= ^head ^ parity_mode[1];
    end
  end
  assign tx = state == START ? 1'b0 : state == DATA ? shifter[0] : state == PARITY ? par_bit : 1'b1;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
  assign tx = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shifter  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      overflow <= (valid && !rdy) || (overflow && !clr_overflow);
      if (pop || tick) baud <= RELOAD;
      else if (busy) baud <= baud - CW'(1);
      if (pop) shifter <= head;
      else if (state == DATA && tick) shifter <= shifter >> 1;
      bit_idx  <= state == DATA ? bit_idx + BW'(tick) : '0;
      stop_idx <= state == STOP ? stop_idx ^ tick : 1'b0;
      case (state)
        IDLE:   if (pop) state <= START;
        START:  if (tick) state <= DATA;
`ifdef UART_TX_PARITY_EN
        DATA:   if (tick && bit_idx == LAST_BIT) state <= par_en ? PARITY : STOP;
        PARITY: if (tick) state <= STOP;
`else
        DATA:   if (tick && bit_idx == LAST_BIT) state <= STOP;
`endif
        STOP:   if (last_stop) state <= pop ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg (8N1 depth-4 instance and 5-data/2-stop instance)
module tb_uart_tx_cfg;
  localparam int LOGN = 4096;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] pm = 2'b00;
  logic valid0 = 1'b0, clr0 = 1'b0;
  logic [7:0] din0 = '0;
  logic rdy0, tx0, busy0, ovf0;
  logic [2:0] count0;
  logic valid1 = 1'b0, clr1 = 1'b0;
  logic [4:0] din1 = '0;
  logic rdy1, tx1, busy1, ovf1;
  logic [2:0] count1;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic txl [2][LOGN];
  logic bsl [2][LOGN];
  logic [2:0] cnl [LOGN];
  logic [15:0] p_vec [4];
  int p_n [4];
  logic [1:0] p_mode [4];

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_HZ(10), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .valid(valid0), .din(din0), .rdy(rdy0), .parity_mode(pm),
    .clr_overflow(clr0), .tx(tx0), .busy(busy0), .count(count0), .overflow(ovf0));

  uart_tx_cfg #(.CLK_HZ(10), .BAUD(1), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .valid(valid1), .din(din1), .rdy(rdy1), .parity_mode(pm),
    .clr_overflow(clr1), .tx(tx1), .busy(busy1), .count(count1), .overflow(ovf1));

  // index j holds the outputs as they stand after the j-th rising edge
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      txl[0][cyc] = tx0;
      txl[1][cyc] = tx1;
      bsl[0][cyc] = busy0;
      bsl[1][cyc] = busy1;
      cnl[cyc] = count0;
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send0(input logic [7:0] d);
    din0 = d;
    valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
  endtask

  task automatic send1(input logic [4:0] d);
    din1 = d;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy0 || busy1 || count0 != 0 || count1 != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 32'(t < 2000), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic int find_start(input int i, input int from);
    for (int j = from; j < cyc; j++) if (txl[i][j] == 1'b0) return j;
    return cyc;
  endfunction

  function automatic int busy_run(input int i, input int s);
    int r;
    r = 0;
    while (s + r < cyc && bsl[i][s + r]) r++;
    return r;
  endfunction

  function automatic logic [15:0] f8(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic check_frame(input int i, input string tag, input int s, input logic [15:0] vec, input int n);
    logic [15:0] obs, unstable;
    obs = '0;
    unstable = '0;
    chk({tag, "_in_log"}, 32'(s >= 0 && s + n * 10 <= cyc), 1);
    if (s >= 0 && s + n * 10 <= cyc) begin
      for (int b = 0; b < n; b++) begin
        obs[b] = txl[i][s + b * 10];
        for (int c = 1; c < 10; c++) if (txl[i][s + b * 10 + c] != obs[b]) unstable[b] = 1'b1;
      end
      chk(tag, obs, vec);
      chk({tag, "_stable"}, unstable, 0);
    end
  endtask

  initial begin
    int k, s, kr;
    p_mode = '{2'b01, 2'b10, 2'b00, 2'b11};
`ifdef UART_TX_PARITY_EN
    p_vec = '{16'h060E, 16'h040E, 16'h020E, 16'h020E};
    p_n = '{11, 11, 10, 10};
`else
    p_vec = '{16'h020E, 16'h020E, 16'h020E, 16'h020E};
    p_n = '{10, 10, 10, 10};
`endif
    repeat (2) @(posedge clk); #1;
    chk("rst_tx", tx0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_count", count0, 0);
    chk("rst_rdy", rdy0, 1);
    chk("rst_ovf", ovf0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    // single 0x55 frame, latency and busy width
    k = cyc;
    send0(8'h55);
    wait_idle();
    chk("t1_count", cnl[k + 1], 1);
    s = find_start(0, k);
    chk("t1_lat", s, k + 2);
    check_frame(0, "t1_frame", s, f8(8'h55), 10);
    chk("t1_busy_pre", bsl[0][s - 1], 0);
    chk("t1_busy", busy_run(0, s), 100);
    // parity modes, each flipped right after the pop
    for (int i = 0; i < 4; i++) begin
      pm = p_mode[i];
      k = cyc;
      send0(8'h07);
      @(posedge clk); #1;
      pm = ~p_mode[i];
      wait_idle();
      s = find_start(0, k);
      chk($sformatf("t2_lat%0d", i), s, k + 2);
      check_frame(0, $sformatf("t2_frame%0d", i), s, p_vec[i], p_n[i]);
      chk($sformatf("t2_busy%0d", i), busy_run(0, s), p_n[i] * 10);
    end
    pm = 2'b00;
    // three back-to-back writes
    k = cyc;
    send0(8'h11);
    send0(8'h22);
    send0(8'h33);
    wait_idle();
    chk("t3_cnt1", cnl[k + 1], 1);
    chk("t3_cnt2", cnl[k + 2], 1);
    chk("t3_cnt3", cnl[k + 3], 2);
    s = find_start(0, k);
    chk("t3_lat", s, k + 2);
    check_frame(0, "t3_f0", s, f8(8'h11), 10);
    check_frame(0, "t3_f1", s + 100, f8(8'h22), 10);
    check_frame(0, "t3_f2", s + 200, f8(8'h33), 10);
    chk("t3_busy", busy_run(0, s), 300);
    chk("t3_drain0", cnl[s + 99], 2);
    chk("t3_drain1", cnl[s + 100], 1);
    chk("t3_drain2", cnl[s + 200], 0);
    // overflow with the FIFO full while a frame is on the line
    k = cyc;
    send0(8'hA1);
    repeat (10) begin @(posedge clk); #1; end
    send0(8'hB1);
    send0(8'hB2);
    send0(8'hB3);
    send0(8'hB4);
    chk("t4_full_rdy", rdy0, 0);
    chk("t4_full_ovf", ovf0, 0);
    send0(8'hEE);
    chk("t4_ovf_set", ovf0, 1);
    chk("t4_ovf_count", count0, 4);
    din0 = 8'hDD;
    valid0 = 1'b1;
    clr0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    clr0 = 1'b0;
    chk("t4_set_wins", ovf0, 1);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    chk("t4_clr", ovf0, 0);
    chk("t4_count_kept", count0, 4);
    while (cyc < k + 2 + 199) begin @(posedge clk); #1; end
    send0(8'hC7);
    chk("t4_push_pop_cnt", count0, 3);
    chk("t4_push_pop_ovf", ovf0, 0);
    wait_idle();
    s = find_start(0, k);
    chk("t4_lat", s, k + 2);
    check_frame(0, "t4_a1", s, f8(8'hA1), 10);
    check_frame(0, "t4_b1", s + 100, f8(8'hB1), 10);
    check_frame(0, "t4_b2", s + 200, f8(8'hB2), 10);
    check_frame(0, "t4_b3", s + 300, f8(8'hB3), 10);
    check_frame(0, "t4_b4", s + 400, f8(8'hB4), 10);
    check_frame(0, "t4_c7", s + 500, f8(8'hC7), 10);
    chk("t4_busy", busy_run(0, s), 600);
    // reset during data bit 3 with two words queued
    k = cyc;
    send0(8'h3C);
    send0(8'h5A);
    send0(8'h66);
    while (cyc < k + 2 + 44) begin @(posedge clk); #1; end
    chk("t5_mid_busy", busy0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("t5_tx", tx0, 1);
    chk("t5_busy", busy0, 0);
    chk("t5_count", count0, 0);
    chk("t5_rdy", rdy0, 1);
    kr = cyc;
    repeat (20) begin @(posedge clk); #1; end
    chk("t5_quiet", find_start(0, kr), cyc);
    k = cyc;
    send0(8'hA3);
    wait_idle();
    s = find_start(0, k);
    chk("t5_lat", s, k + 2);
    check_frame(0, "t5_a3", s, f8(8'hA3), 10);
    chk("t5_busy_len", busy_run(0, s), 100);
    // 5 data bits, 2 stop bits
    k = cyc;
    send1(5'h1F);
    wait_idle();
    s = find_start(1, k);
    chk("t6_lat", s, k + 2);
    check_frame(1, "t6_1f", s, {8'b0, 2'b11, 5'h1F, 1'b0}, 8);
    chk("t6_busy", busy_run(1, s), 80);
    pm = 2'b01;
    k = cyc;
    send1(5'h0A);
    send1(5'h0B);
    wait_idle();
    s = find_start(1, k);
    chk("t6_lat2", s, k + 2);
`ifdef UART_TX_PARITY_EN
    check_frame(1, "t6_0a", s, {7'b0, 2'b11, 1'b0, 5'h0A, 1'b0}, 9);
    check_frame(1, "t6_0b", s + 90, {7'b0, 2'b11, 1'b1, 5'h0B, 1'b0}, 9);
    chk("t6_busy2", busy_run(1, s), 180);
`else
    check_frame(1, "t6_0a", s, {8'b0, 2'b11, 5'h0A, 1'b0}, 8);
    check_frame(1, "t6_0b", s + 80, {8'b0, 2'b11, 5'h0B, 1'b0}, 8);
    chk("t6_busy2", busy_run(1, s), 160);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
